// File: rtl/mmio_led_pwm.sv
// rtl/mmio_led_pwm.sv - memory-mapped LED outputs with direct and PWM-dimmed channels (readback: MMIO_LED_READBACK_EN)
module mmio_led_pwm #(
  parameter int          pChannels = 8,
  parameter int          pPwmBits  = 8,
  parameter logic [31:0] pBaseAddr = 32'h0000_1000
) (
  input  logic                 iwClk,
  input  logic                 iwRst,
  input  logic [31:0]          iwReadAddr,
  input  logic [31:0]          iwWriteAddr,
  input  logic [31:0]          iwWriteData,
  input  logic [3:0]           iwWstrb,
  output logic [31:0]          owReadData,
  output logic [pChannels-1:0] owLed
);

  localparam logic [5:0] kOffCtrl     = 6'h00;
  localparam logic [5:0] kOffDirect   = 6'h01;
  localparam logic [5:0] kOffMode     = 6'h02;
  localparam logic [5:0] kOffPrescale = 6'h03;
  localparam logic [5:0] kOffStatus   = 6'h04;
  localparam int         kOffDuty     = 16;

  logic                 ctrlEn;
  logic [pChannels-1:0] directReg;
  logic [pChannels-1:0] modeReg;
  logic [15:0]          prescaleReg;
  logic [15:0]          pre;
  logic [pPwmBits-1:0]  cnt;
  logic [pPwmBits-1:0]  dutyProg [pChannels];
  logic [pPwmBits-1:0]  dutyAct  [pChannels];

  logic                 wHit;
  logic [5:0]           wOff;
  logic [31:0]          wMerged;
  logic                 tick;
  logic                 cntWrap;
  logic [pChannels-1:0] ledNext;
  logic                 unusedAddrBits;

  // Zero-extended register contents at a word offset; unmapped offsets read 0
  function automatic logic [31:0] regValue(input logic [5:0] off);
    logic [31:0] v;
    v = '0;
    case (off)
      kOffCtrl:     v = {31'h0, ctrlEn};
      kOffDirect:   v = 32'(directReg);
      kOffMode:     v = 32'(modeReg);
      kOffPrescale: v = {16'h0, prescaleReg};
      kOffStatus:   v = 32'(cnt);
      default:      v = '0;
    endcase
    for (int n = 0; n < pChannels; n++) begin
      if (off == 6'(kOffDuty + n)) v = 32'(dutyProg[n]);
    end
    return v;
  endfunction

  // Byte-lane merge of new write data over the current contents
  function automatic logic [31:0] mergeLanes(input logic [31:0] oldVal, input logic [31:0] newVal,
                                             input logic [3:0] strb);
    logic [31:0] v;
    v = oldVal;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) v[b*8 +: 8] = newVal[b*8 +: 8];
    end
    return v;
  endfunction

  assign wHit    = (iwWriteAddr[31:8] == pBaseAddr[31:8]) && (iwWstrb != 4'b0000);
  assign wOff    = iwWriteAddr[7:2];
  assign wMerged = mergeLanes(regValue(wOff), iwWriteData, iwWstrb);
  assign tick    = (pre == prescaleReg);
  assign cntWrap = tick && (cnt == {pPwmBits{1'b1}});

  // Register writes, prescaler, PWM counter and duty shadow update
  always_ff @(posedge iwClk) begin
    if (iwRst) begin
      ctrlEn      <= 1'b0;
      directReg   <= '0;
      modeReg     <= '0;
      prescaleReg <= '0;
      pre         <= '0;
      cnt         <= '0;
      for (int n = 0; n < pChannels; n++) begin
        dutyProg[n] <= '0;
        dutyAct[n]  <= '0;
      end
    end else begin
      if (wHit && wOff == kOffCtrl)   ctrlEn    <= wMerged[0];
      if (wHit && wOff == kOffDirect) directReg <= wMerged[pChannels-1:0];
      if (wHit && wOff == kOffMode)   modeReg   <= wMerged[pChannels-1:0];
      if (wHit && wOff == kOffPrescale) begin
        prescaleReg <= wMerged[15:0];
        pre         <= '0;
      end else if (tick) begin
        pre <= '0;
      end else begin
        pre <= pre + 16'd1;
      end
      if (tick) cnt <= cnt + 1'b1;
      // Active duties switch only at the period boundary so a pulse is never cut short
      for (int n = 0; n < pChannels; n++) begin
        if (cntWrap) dutyAct[n] <= dutyProg[n];
        if (wHit && wOff == 6'(kOffDuty + n)) dutyProg[n] <= wMerged[pPwmBits-1:0];
      end
    end
  end

  // Per-channel output selection gated by the global enable
  always_comb begin
    ledNext = '0;
    for (int n = 0; n < pChannels; n++) begin
      ledNext[n] = ctrlEn & (modeReg[n] ? ((dutyAct[n] == {pPwmBits{1'b1}}) | (cnt < dutyAct[n]))
                                        : directReg[n]);
    end
  end

  // Registered LED outputs
  always_ff @(posedge iwClk) begin
    if (iwRst) owLed <= '0;
    else       owLed <= ledNext;
  end

`ifdef MMIO_LED_READBACK_EN
  // Registered read port, returns pre-write contents on a same-cycle write
  always_ff @(posedge iwClk) begin
    if (iwRst)                                      owReadData <= '0;
    else if (iwReadAddr[31:8] == pBaseAddr[31:8])   owReadData <= regValue(iwReadAddr[7:2]);
    else                                            owReadData <= '0;
  end
  assign unusedAddrBits = ^{iwWriteAddr[1:0], iwReadAddr[1:0], wMerged};
`else
  assign owReadData     = '0;
  assign unusedAddrBits = ^{iwWriteAddr[1:0], iwReadAddr, wMerged};
`endif

endmodule
